spi_exe_master: RTL

//  SPI master that drives the SPI execution-unit slave over the 4-wire link from the system clock.
//  - Takes argA, argB and an operation byte from the host side.
//  - Serialises them MSB-first on MOSI as one CS-low frame, then clocks back the 8-bit result and 4 flags.
//  - Sits directly upstream of the slave; the host sees a start/done handshake.

---
 rtl/spi_exe_pkg.sv | 24 ++
 rtl/spi_exe_master_if.sv | 41 ++++
 rtl/spi_clk_gen.sv | 37 +++
 rtl/spi_exe_master.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/spi_exe_pkg.sv
// rtl/spi_exe_pkg.sv - shared types and constants for the SPI execution-unit master
package spi_exe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TX,
        GAP,
        RX,
        DONE,
        HOLD
    } state_t;

    localparam int M       = 8;
    localparam int N_FLAGS = 4;
    localparam int TX_BITS = 24;
    localparam int RX_BITS = 12;

    localparam int SF = 0;
    localparam int OF = 1;
    localparam int NF = 2;
    localparam int BF = 3;

endpackage

// File: rtl/spi_exe_master_if.sv
// rtl/spi_exe_master_if.sv - host handshake and 4-wire SPI bundle (SPI_ABORT_EN adds i_abort/o_err)
interface spi_exe_master_if;
    import spi_exe_pkg::*;

    logic               i_start;
    logic [M-1:0]       i_argA;
    logic [M-1:0]       i_argB;
    logic [M-1:0]       i_oper;
    logic               o_busy;
    logic               o_done;
    logic [M-1:0]       o_result;
    logic [N_FLAGS-1:0] o_flags;
    logic               o_sclk;
    logic               o_mosi;
    logic               i_miso;
    logic               o_cs;

`ifdef SPI_ABORT_EN
    logic               i_abort;
    logic               o_err;

    modport master (
        input  i_start, i_argA, i_argB, i_oper, i_miso, i_abort,
        output o_busy, o_done, o_result, o_flags, o_sclk, o_mosi, o_cs, o_err
    );
    modport slave (
        output i_start, i_argA, i_argB, i_oper, i_miso, i_abort,
        input  o_busy, o_done, o_result, o_flags, o_sclk, o_mosi, o_cs, o_err
    );
`else
    modport master (
        input  i_start, i_argA, i_argB, i_oper, i_miso,
        output o_busy, o_done, o_result, o_flags, o_sclk, o_mosi, o_cs
    );
    modport slave (
        output i_start, i_argA, i_argB, i_oper, i_miso,
        input  o_busy, o_done, o_result, o_flags, o_sclk, o_mosi, o_cs
    );
`endif

endinterface

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK half-period divider with tick, rise and fall strobes
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk_p,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_sclk_en,
    output logic o_tick,
    output logic o_rise,
    output logic o_fall,
    output logic o_sclk
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign o_tick = i_en && (cnt == CW'(CLK_DIV - 1));
    assign o_rise = o_tick && i_sclk_en && !o_sclk;
    assign o_fall = o_tick && i_sclk_en && o_sclk;

    // The counter restarts from zero every time the FSM re-enables it.
    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            o_sclk <= 1'b0;
        end else begin
            if (!i_en || o_tick) cnt <= '0;
            else                 cnt <= cnt + CW'(1);

            if (!i_sclk_en)  o_sclk <= 1'b0;
            else if (o_tick) o_sclk <= ~o_sclk;
        end
    end

endmodule

// File: rtl/spi_exe_master.sv
// rtl/spi_exe_master.sv - SPI master framing {A,B,OPER} out and 12-bit result/flags back
// Optional abort path compiled in with SPI_ABORT_EN.
module spi_exe_master
    import spi_exe_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int GAP_BITS = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic              i_clk_p,
    input  logic              i_rst_n,
    spi_exe_master_if.master  bus
);

    localparam logic [4:0] TX_CNT   = 5'(TX_BITS);
    localparam logic [4:0] GAP_CNT  = 5'(GAP_BITS);
    localparam logic [4:0] RX_CNT   = 5'(RX_BITS);
    localparam logic [4:0] HOLD_CNT = 5'(2 * CS_IDLE);

    state_t              state, state_n;
    logic [4:0]          bit_cnt, cnt_val;
    logic                load_cnt, dec_cnt, accept;
    logic                clk_en, sclk_en, abort_take;
    logic                tick, rise, fall, sclk;
    logic [TX_BITS-1:0]  tx_sr;
    logic [RX_BITS-1:0]  rx_sr, rx_next;
    logic                cs, mosi, busy, done;
    logic [M-1:0]        result;
    logic [N_FLAGS-1:0]  flags;

    assign clk_en  = (state != IDLE) && (state != DONE);
    assign sclk_en = ((state == TX) || (state == GAP) || (state == RX)) && !abort_take;
    assign rx_next = {rx_sr[RX_BITS-2:0], bus.i_miso};

`ifdef SPI_ABORT_EN
    logic abort_pend, err, active;

    assign active     = (state == SETUP) || (state == TX) || (state == GAP) || (state == RX);
    assign abort_take = tick && active && (abort_pend || bus.i_abort);

    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            abort_pend <= 1'b0;
            err        <= 1'b0;
        end else begin
            abort_pend <= active && !abort_take && (abort_pend || bus.i_abort);
            err        <= abort_take;
        end
    end

    assign bus.o_err = err;
`else
    assign abort_take = 1'b0;
`endif

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .i_clk_p   (i_clk_p),
        .i_rst_n   (i_rst_n),
        .i_en      (clk_en),
        .i_sclk_en (sclk_en),
        .o_tick    (tick),
        .o_rise    (rise),
        .o_fall    (fall),
        .o_sclk    (sclk)
    );

    // Bit counter counts down on SCLK rises; each phase ends on the fall after it hits zero.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        load_cnt = 1'b0;
        cnt_val  = '0;
        dec_cnt  = rise || (tick && (state == HOLD));
        case (state)
            IDLE: if (bus.i_start) begin
                accept  = 1'b1;
                state_n = SETUP;
            end
            SETUP: if (tick) begin
                state_n  = TX;
                load_cnt = 1'b1;
                cnt_val  = TX_CNT;
            end
            TX: if (fall && bit_cnt == '0) begin
                state_n  = GAP;
                load_cnt = 1'b1;
                cnt_val  = GAP_CNT;
            end
            GAP: if (fall && bit_cnt == '0) begin
                state_n  = RX;
                load_cnt = 1'b1;
                cnt_val  = RX_CNT;
            end
            RX: if (fall && bit_cnt == '0) state_n = DONE;
            DONE: begin
                state_n  = HOLD;
                load_cnt = 1'b1;
                cnt_val  = HOLD_CNT;
            end
            HOLD: if (tick && bit_cnt == 5'd1) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort_take) begin
            state_n  = HOLD;
            load_cnt = 1'b1;
            cnt_val  = HOLD_CNT;
        end
    end

    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            flags   <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);

            if (load_cnt)     bit_cnt <= cnt_val;
            else if (dec_cnt) bit_cnt <= bit_cnt - 5'd1;

            if (accept) begin
                tx_sr <= {bus.i_argA, bus.i_argB, bus.i_oper};
                mosi  <= bus.i_argA[M-1];
                cs    <= 1'b0;
            end else if (state == TX && fall) begin
                tx_sr <= tx_sr << 1;
                mosi  <= (bit_cnt == '0) ? 1'b0 : tx_sr[TX_BITS-2];
            end

            if (state == RX && fall) begin
                rx_sr <= rx_next;
                if (bit_cnt == '0) begin
                    result <= rx_next[RX_BITS-1:N_FLAGS];
                    flags  <= {rx_next[BF], rx_next[NF], rx_next[OF], rx_next[SF]};
                end
            end

            if (state_n == DONE || abort_take) cs <= 1'b1;
            if (abort_take) mosi <= 1'b0;
        end
    end

    assign bus.o_cs     = cs;
    assign bus.o_sclk   = sclk;
    assign bus.o_mosi   = mosi;
    assign bus.o_busy   = busy;
    assign bus.o_done   = done;
    assign bus.o_result = result;
    assign bus.o_flags  = flags;

endmodule
